axi_ram_responder: RTL and testbench



---
 rtl/axi_ram_responder_pkg.sv | 25 ++
 rtl/axi_ram_rd_skid.sv | 44 ++++
 rtl/axi_ram_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_ram_responder.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ram_responder_pkg.sv
// Shared definitions for the AXI RAM responder: response codes, burst codes,
// responder FSM states and a burst-type helper.
package axi_ram_responder_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      WRESP = 2'd2,
      READ  = 2'd3
   } state_t;

   // INCR and WRAP both step one word per beat; WRAP boundaries are not
   // modelled, the index simply rolls over at the top of the RAM.
   function automatic logic burst_advances(input logic [1:0] burst);
      return (burst == BURST_INCR) || (burst == BURST_WRAP);
   endfunction

endpackage

// File: rtl/axi_ram_rd_skid.sv
// Two-entry read-data skid buffer. The responder only pushes when it holds a
// credit, so push never arrives while full. Head contents stay put while the
// consumer stalls.
module axi_ram_rd_skid #(
   parameter int WIDTH = 129
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             valid,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] slot [2];
   logic             wr_ptr;
   logic             rd_ptr;

   // Storage, pointers and occupancy; reset empties the buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot[0] <= '0;
         slot[1] <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count   <= 2'd0;
      end else begin
         if (push) begin
            slot[wr_ptr] <= push_data;
            wr_ptr       <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign valid = (count != 2'd0);
   assign head  = slot[rd_ptr];

endmodule

// File: rtl/axi_ram_responder.sv
// AXI4 RAM responder on a combined read/write address channel, one burst at
// a time. Optional macro AXI_RAM_RESP_CHECK_EN enables SLVERR reporting for
// out-of-range start addresses and wlast mismatches; without it the upper
// address bits alias and every response is OKAY.
//
// state | meaning
// IDLE  | o_aready high, waiting for an address handshake
// WRITE | accepting write beats, o_wready high
// WRESP | presenting the write response until i_bready
// READ  | streaming read beats through the skid buffer
module axi_ram_responder
   import axi_ram_responder_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 8,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                    axi_clk,
   input  logic                    reset,
   input  logic                    i_avalid,
   output logic                    o_aready,
   input  logic [ADDR_WIDTH-1:0]   i_aaddr,
   input  logic [ID_WIDTH-1:0]     i_aid,
   input  logic [7:0]              i_alen,
   input  logic [2:0]              i_asize,
   input  logic [1:0]              i_aburst,
   input  logic [1:0]              i_alock,
   input  logic                    i_atype,
   input  logic [ID_WIDTH-1:0]     i_wid,
   input  logic                    i_wvalid,
   output logic                    o_wready,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_strb,
   input  logic                    i_wlast,
   output logic                    o_bvalid,
   input  logic                    i_bready,
   output logic [ID_WIDTH-1:0]     o_bid,
   output logic [1:0]              o_bresp,
   output logic                    o_rvalid,
   input  logic                    i_rready,
   output logic [DATA_WIDTH-1:0]   o_rdata,
   output logic [ID_WIDTH-1:0]     o_rid,
   output logic [1:0]              o_rresp,
   output logic                    o_rlast
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFF    = $clog2(STRB_W);
   localparam int IDX_HI = DEPTH_LOG2 + OFF;
   localparam int DEPTH  = 1 << DEPTH_LOG2;

   state_t                  state;
   state_t                  state_nx;
   logic                    aready_en;
   logic [ID_WIDTH-1:0]     id_q;
   logic [7:0]              alen_q;
   logic [7:0]              wcnt;
   logic [8:0]              icnt;
   logic                    adv_q;
   logic                    oor_q;
   logic [DEPTH_LOG2-1:0]   idx_q;
   logic [1:0]              resp_q;
   logic                    rd_pend;
   logic                    rd_last_q;
   logic [DATA_WIDTH-1:0]   rd_data_q;
   logic [DATA_WIDTH-1:0]   ram [DEPTH];

   logic                    a_hs;
   logic                    a_oor;
   logic                    w_beat;
   logic                    w_at_last;
   logic                    w_end;
   logic                    w_bad;
   logic                    rd_issue;
   logic [1:0]              occ;
   logic                    sk_valid;
   logic                    sk_pop;
   logic [1:0]              sk_count;
   logic [DATA_WIDTH:0]     sk_head;

   logic                    unused_ok;
   assign unused_ok = ^{i_alock, i_wid, i_asize, i_aaddr};

`ifdef AXI_RAM_RESP_CHECK_EN
   assign a_oor = (i_aaddr >> IDX_HI) != '0;
   assign w_bad = i_wlast != w_at_last;
`else
   assign a_oor = 1'b0;
   assign w_bad = 1'b0;
`endif

   assign a_hs      = (state == IDLE) && aready_en && i_avalid;
   assign w_beat    = (state == WRITE) && i_wvalid;
   assign w_at_last = (wcnt == alen_q);
   assign w_end     = w_beat && (i_wlast || w_at_last);
   assign sk_pop    = sk_valid && i_rready;

   // A RAM read is issued only if it still fits in the skid buffer once the
   // in-flight read lands, which keeps one beat per cycle without overflow.
   assign occ      = sk_count + {1'b0, rd_pend} - {1'b0, sk_pop};
   assign rd_issue = (state == READ) && (icnt <= {1'b0, alen_q}) && !occ[1];

   // FSM state register.
   always_ff @(posedge axi_clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nx = state;
      o_aready = 1'b0;
      o_wready = 1'b0;
      o_bvalid = 1'b0;
      case (state)
         IDLE: begin
            o_aready = aready_en;
            if (a_hs) begin
               state_nx = i_atype ? WRITE : READ;
            end
         end
         WRITE: begin
            o_wready = 1'b1;
            if (w_end) begin
               state_nx = WRESP;
            end
         end
         WRESP: begin
            o_bvalid = 1'b1;
            if (i_bready) begin
               state_nx = IDLE;
            end
         end
         READ: begin
            if (sk_pop && sk_head[DATA_WIDTH]) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Burst context, beat counters, word index and the RAM read pipeline stage.
   always_ff @(posedge axi_clk) begin
      if (reset) begin
         aready_en <= 1'b0;
         id_q      <= '0;
         alen_q    <= '0;
         adv_q     <= 1'b0;
         oor_q     <= 1'b0;
         idx_q     <= '0;
         resp_q    <= RESP_OKAY;
         wcnt      <= '0;
         icnt      <= '0;
         rd_pend   <= 1'b0;
         rd_last_q <= 1'b0;
         rd_data_q <= '0;
      end else begin
         aready_en <= 1'b1;
         rd_pend   <= rd_issue;
         if (a_hs) begin
            id_q   <= i_aid;
            alen_q <= i_alen;
            adv_q  <= burst_advances(i_aburst);
            oor_q  <= a_oor;
            idx_q  <= i_aaddr[IDX_HI-1:OFF];
            resp_q <= a_oor ? RESP_SLVERR : RESP_OKAY;
            wcnt   <= '0;
            icnt   <= '0;
         end
         if (w_beat) begin
            wcnt <= wcnt + 8'd1;
            if (adv_q) begin
               idx_q <= idx_q + DEPTH_LOG2'(1);
            end
            if (w_bad) begin
               resp_q <= RESP_SLVERR;
            end
         end
         if (rd_issue) begin
            icnt      <= icnt + 9'd1;
            rd_last_q <= (icnt == {1'b0, alen_q});
            rd_data_q <= oor_q ? '0 : ram[idx_q];
            if (adv_q) begin
               idx_q <= idx_q + DEPTH_LOG2'(1);
            end
         end
      end
   end

   // RAM byte writes; no reset so contents survive a mid-burst reset.
   always_ff @(posedge axi_clk) begin
      if (!reset && w_beat && !oor_q) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (i_strb[b]) begin
               ram[idx_q][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
         end
      end
   end

   axi_ram_rd_skid #(
      .WIDTH (DATA_WIDTH + 1)
   ) u_rd_skid (
      .clk       (axi_clk),
      .reset     (reset),
      .push      (rd_pend),
      .push_data ({rd_last_q, rd_data_q}),
      .pop       (sk_pop),
      .valid     (sk_valid),
      .head      (sk_head),
      .count     (sk_count)
   );

   assign o_rvalid = sk_valid;
   assign o_rdata  = sk_head[DATA_WIDTH-1:0];
   assign o_rlast  = sk_valid && sk_head[DATA_WIDTH];
   assign o_rid    = id_q;
   assign o_rresp  = resp_q;
   assign o_bid    = id_q;
   assign o_bresp  = resp_q;

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed bench for axi_ram_responder. Expectations follow the build:
// with AXI_RAM_RESP_CHECK_EN defined, bad bursts expect SLVERR; otherwise
// aliasing and OKAY.
module tb_axi_ram_responder;

   localparam int DW = 128;
   localparam int AW = 32;
   localparam int IW = 8;
   localparam int DL = 10;

   logic          axi_clk = 1'b0;
   logic          reset = 1'b1;
   logic          i_avalid = 1'b0;
   logic          o_aready;
   logic [AW-1:0] i_aaddr = '0;
   logic [IW-1:0] i_aid = '0;
   logic [7:0]    i_alen = '0;
   logic [2:0]    i_asize = 3'd4;
   logic [1:0]    i_aburst = 2'd1;
   logic [1:0]    i_alock = '0;
   logic          i_atype = 1'b0;
   logic [IW-1:0] i_wid = '0;
   logic          i_wvalid = 1'b0;
   logic          o_wready;
   logic [DW-1:0] i_wdata = '0;
   logic [15:0]   i_strb = '0;
   logic          i_wlast = 1'b0;
   logic          o_bvalid;
   logic          i_bready = 1'b0;
   logic [IW-1:0] o_bid;
   logic [1:0]    o_bresp;
   logic          o_rvalid;
   logic          i_rready = 1'b0;
   logic [DW-1:0] o_rdata;
   logic [IW-1:0] o_rid;
   logic [1:0]    o_rresp;
   logic          o_rlast;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] wbuf [16];
   logic [DW-1:0] rbuf [16];
   logic          rlbuf [16];

   always #5 axi_clk = ~axi_clk;

   axi_ram_responder #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .ID_WIDTH (IW), .DEPTH_LOG2 (DL)
   ) dut (
      .axi_clk (axi_clk), .reset (reset),
      .i_avalid (i_avalid), .o_aready (o_aready), .i_aaddr (i_aaddr),
      .i_aid (i_aid), .i_alen (i_alen), .i_asize (i_asize),
      .i_aburst (i_aburst), .i_alock (i_alock), .i_atype (i_atype),
      .i_wid (i_wid), .i_wvalid (i_wvalid), .o_wready (o_wready),
      .i_wdata (i_wdata), .i_strb (i_strb), .i_wlast (i_wlast),
      .o_bvalid (o_bvalid), .i_bready (i_bready), .o_bid (o_bid),
      .o_bresp (o_bresp), .o_rvalid (o_rvalid), .i_rready (i_rready),
      .o_rdata (o_rdata), .o_rid (o_rid), .o_rresp (o_rresp),
      .o_rlast (o_rlast)
   );

   // Address phase; returns just after the handshake edge.
   task automatic axi_addr(input logic [31:0] addr, input logic [7:0] id,
                           input logic [7:0] len, input logic [1:0] burst,
                           input logic typ);
      int n = 0;
      i_avalid = 1'b1; i_aaddr = addr; i_aid = id; i_alen = len;
      i_aburst = burst; i_atype = typ;
      while (o_aready !== 1'b1 && n < 50) begin
         @(posedge axi_clk); #1; n++;
      end
      if (o_aready !== 1'b1) begin
         failures++;
         $display("FAIL addr_timeout aready=%b expected 1", o_aready);
      end
      @(posedge axi_clk); #1;
      i_avalid = 1'b0;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [7:0] id,
                            input logic [7:0] len, input logic [1:0] burst,
                            input logic [15:0] strb, input int nbeats,
                            input int wlast_idx,
                            output logic [1:0] bresp, output logic [7:0] bid);
      int n = 0;
      axi_addr(addr, id, len, burst, 1'b1);
      for (int b = 0; b < nbeats; b++) begin
         i_wvalid = 1'b1; i_wdata = wbuf[b]; i_strb = strb;
         i_wlast = (b == wlast_idx);
         @(posedge axi_clk); #1;
      end
      i_wvalid = 1'b0; i_wlast = 1'b0;
      while (o_bvalid !== 1'b1 && n < 50) begin
         @(posedge axi_clk); #1; n++;
      end
      if (o_bvalid !== 1'b1) begin
         failures++;
         $display("FAIL bvalid_timeout bvalid=%b expected 1", o_bvalid);
      end
      bresp = o_bresp; bid = o_bid;
      i_bready = 1'b1;
      @(posedge axi_clk); #1;
      i_bready = 1'b0;
   endtask

   // Collects beats into rbuf/rlbuf; counts data changes seen during stalls.
   task automatic axi_read(input logic [31:0] addr, input logic [7:0] id,
                           input logic [7:0] len, input logic [1:0] burst,
                           input bit toggle, output int nbeats, output int lat,
                           output int stall_bad, output logic [7:0] rid,
                           output logic [1:0] rresp);
      logic [DW-1:0] hdata;
      logic          hlast;
      bit            held = 0;
      bit            done = 0;
      nbeats = 0; lat = -1; stall_bad = 0; rid = '0; rresp = '0;
      hdata = '0; hlast = 1'b0;
      axi_addr(addr, id, len, burst, 1'b0);
      for (int c = 0; c < 100 && !done; c++) begin
         i_rready = toggle ? (c % 2 == 0) : 1'b1;
         if (o_rvalid === 1'b1) begin
            if (lat < 0) lat = c;
            if (held && (o_rdata !== hdata || o_rlast !== hlast)) stall_bad++;
            if (i_rready) begin
               if (nbeats < 16) begin
                  rbuf[nbeats] = o_rdata; rlbuf[nbeats] = o_rlast;
               end
               rid = o_rid; rresp = o_rresp;
               nbeats++; held = 0;
               if (o_rlast === 1'b1) done = 1;
            end else begin
               held = 1; hdata = o_rdata; hlast = o_rlast;
            end
         end
         @(posedge axi_clk); #1;
      end
      i_rready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge axi_clk);
      #1;
      checks++;
      if ({o_aready, o_wready, o_bvalid, o_rvalid, o_rlast, o_bid, o_rid, o_bresp, o_rresp} !== '0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b expected all zero",
                  {o_aready, o_wready, o_bvalid, o_rvalid, o_rlast, o_bid, o_rid, o_bresp, o_rresp});
      end
      checks++;
      if (o_rdata !== '0) begin
         failures++;
         $display("FAIL reset_rdata got=%h expected 0", o_rdata);
      end
      reset = 1'b0;
      @(posedge axi_clk); #1;
      checks++;
      if (o_aready !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_aready got=%b expected 1", o_aready);
      end
   endtask

   task automatic test_incr_write_read();
      logic [1:0] bresp, rresp;
      logic [7:0] bid, rid;
      int nb, lat, sb;
      for (int i = 0; i < 4; i++) wbuf[i] = DW'(i + 1);
      axi_write(32'h100, 8'h5A, 8'd3, 2'd1, 16'hFFFF, 4, 3, bresp, bid);
      checks++;
      if (bresp !== 2'b00) begin failures++; $display("FAIL incr_bresp got=%b expected 00", bresp); end
      checks++;
      if (bid !== 8'h5A) begin failures++; $display("FAIL incr_bid got=%h expected 5a", bid); end
      axi_read(32'h100, 8'hA5, 8'd3, 2'd1, 1'b0, nb, lat, sb, rid, rresp);
      checks++;
      if (nb !== 4) begin failures++; $display("FAIL incr_nbeats got=%0d expected 4", nb); end
      checks++;
      if (lat !== 2) begin failures++; $display("FAIL incr_latency got=%0d expected 2", lat); end
      checks++;
      if (rid !== 8'hA5) begin failures++; $display("FAIL incr_rid got=%h expected a5", rid); end
      checks++;
      if (rresp !== 2'b00) begin failures++; $display("FAIL incr_rresp got=%b expected 00", rresp); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rbuf[i] !== DW'(i + 1)) begin
            failures++; $display("FAIL incr_rdata%0d got=%h expected %0d", i, rbuf[i], i + 1);
         end
         checks++;
         if (rlbuf[i] !== (i == 3)) begin
            failures++; $display("FAIL incr_rlast%0d got=%b", i, rlbuf[i]);
         end
      end
   endtask

   task automatic test_strobe();
      logic [1:0] bresp, rresp;
      logic [7:0] bid, rid;
      logic [DW-1:0] exp;
      int nb, lat, sb;
      exp = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
      wbuf[0] = '0;
      axi_write(32'h40, 8'h01, 8'd0, 2'd1, 16'hFFFF, 1, 0, bresp, bid);
      wbuf[0] = '1;
      axi_write(32'h40, 8'h02, 8'd0, 2'd1, 16'h00FF, 1, 0, bresp, bid);
      axi_read(32'h40, 8'h03, 8'd0, 2'd1, 1'b0, nb, lat, sb, rid, rresp);
      checks++;
      if (nb !== 1 || rbuf[0] !== exp) begin
         failures++; $display("FAIL strobe_rdata got=%h beats=%0d expected %h", rbuf[0], nb, exp);
      end
   endtask

   task automatic test_read_stall();
      logic [1:0] bresp, rresp;
      logic [7:0] bid, rid;
      int nb, lat, sb;
      for (int i = 0; i < 8; i++) wbuf[i] = DW'(32'h1000 + i);
      axi_write(32'h200, 8'h11, 8'd7, 2'd1, 16'hFFFF, 8, 7, bresp, bid);
      axi_read(32'h200, 8'h22, 8'd7, 2'd1, 1'b1, nb, lat, sb, rid, rresp);
      checks++;
      if (nb !== 8) begin failures++; $display("FAIL stall_nbeats got=%0d expected 8", nb); end
      checks++;
      if (sb !== 0) begin failures++; $display("FAIL stall_stability changes=%0d expected 0", sb); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (rbuf[i] !== DW'(32'h1000 + i) || rlbuf[i] !== (i == 7)) begin
            failures++;
            $display("FAIL stall_beat%0d got=%h last=%b expected %h", i, rbuf[i], rlbuf[i], 32'h1000 + i);
         end
      end
      checks++;
      if (o_rvalid !== 1'b0) begin failures++; $display("FAIL stall_extra_beat rvalid=%b expected 0", o_rvalid); end
   endtask

   task automatic test_addr_wrap();
      logic [1:0] bresp, rresp;
      logic [7:0] bid, rid;
      int nb, lat, sb;
      wbuf[0] = DW'(32'hAAAA); wbuf[1] = DW'(32'hBBBB);
      axi_write(32'h3FF0, 8'h31, 8'd1, 2'd1, 16'hFFFF, 2, 1, bresp, bid);
      axi_read(32'h3FF0, 8'h32, 8'd0, 2'd1, 1'b0, nb, lat, sb, rid, rresp);
      checks++;
      if (rbuf[0] !== DW'(32'hAAAA)) begin failures++; $display("FAIL wrap_top got=%h expected aaaa", rbuf[0]); end
      axi_read(32'h0, 8'h33, 8'd0, 2'd1, 1'b0, nb, lat, sb, rid, rresp);
      checks++;
      if (rbuf[0] !== DW'(32'hBBBB)) begin failures++; $display("FAIL wrap_word0 got=%h expected bbbb", rbuf[0]); end
      wbuf[0] = DW'(32'hCCCC);
      axi_write(32'h90, 8'h34, 8'd0, 2'd1, 16'hFFFF, 1, 0, bresp, bid);
      wbuf[0] = DW'(32'hD001); wbuf[1] = DW'(32'hD002); wbuf[2] = DW'(32'hD003);
      axi_write(32'h80, 8'h35, 8'd2, 2'd0, 16'hFFFF, 3, 2, bresp, bid);
      axi_read(32'h80, 8'h36, 8'd1, 2'd1, 1'b0, nb, lat, sb, rid, rresp);
      checks++;
      if (rbuf[0] !== DW'(32'hD003) || rbuf[1] !== DW'(32'hCCCC)) begin
         failures++; $display("FAIL fixed_burst got=%h,%h expected d003,cccc", rbuf[0], rbuf[1]);
      end
   endtask

   task automatic test_check();
      logic [1:0] bresp, rresp, exp_resp;
      logic [7:0] bid, rid;
      logic [DW-1:0] exp_w0, exp_oor_data;
      int nb, lat, sb;
`ifdef AXI_RAM_RESP_CHECK_EN
      exp_resp = 2'b10; exp_w0 = DW'(32'hBBBB); exp_oor_data = '0;
`else
      exp_resp = 2'b00; exp_w0 = DW'(32'hDDDD); exp_oor_data = DW'(32'hDDDD);
`endif
      wbuf[0] = DW'(32'hDDDD);
      axi_write(32'h10000, 8'h41, 8'd0, 2'd1, 16'hFFFF, 1, 0, bresp, bid);
      checks++;
      if (bresp !== exp_resp) begin failures++; $display("FAIL oor_bresp got=%b expected %b", bresp, exp_resp); end
      axi_read(32'h0, 8'h42, 8'd0, 2'd1, 1'b0, nb, lat, sb, rid, rresp);
      checks++;
      if (rbuf[0] !== exp_w0) begin failures++; $display("FAIL oor_ram_word0 got=%h expected %h", rbuf[0], exp_w0); end
      axi_read(32'h10000, 8'h43, 8'd0, 2'd1, 1'b0, nb, lat, sb, rid, rresp);
      checks++;
      if (rresp !== exp_resp || rbuf[0] !== exp_oor_data) begin
         failures++; $display("FAIL oor_read got=%b/%h expected %b/%h", rresp, rbuf[0], exp_resp, exp_oor_data);
      end
      wbuf[0] = DW'(32'hE000); wbuf[1] = DW'(32'hE001);
      axi_write(32'h300, 8'h44, 8'd3, 2'd1, 16'hFFFF, 2, 1, bresp, bid);
      checks++;
      if (bresp !== exp_resp) begin failures++; $display("FAIL early_wlast_bresp got=%b expected %b", bresp, exp_resp); end
      axi_read(32'h300, 8'h45, 8'd1, 2'd1, 1'b0, nb, lat, sb, rid, rresp);
      checks++;
      if (nb !== 2 || rbuf[0] !== DW'(32'hE000) || rbuf[1] !== DW'(32'hE001)) begin
         failures++; $display("FAIL early_wlast_data got=%h,%h beats=%0d expected e000,e001", rbuf[0], rbuf[1], nb);
      end
   endtask

   task automatic test_reset_mid_read();
      logic [1:0] rresp;
      logic [7:0] rid;
      int nb, lat, sb;
      int seen = 0;
      bit found = 0;
      axi_addr(32'h200, 8'h51, 8'd7, 2'd1, 1'b0);
      i_rready = 1'b1;
      for (int c = 0; c < 20 && !found; c++) begin
         if (o_rvalid === 1'b1 && seen == 1) found = 1;
         else begin
            if (o_rvalid === 1'b1) seen++;
            @(posedge axi_clk); #1;
         end
      end
      checks++;
      if (!found) begin failures++; $display("FAIL midreset_beat2 seen=%0d expected beat 2 presented", seen); end
      reset = 1'b1;
      @(posedge axi_clk); #1;
      checks++;
      if (o_rvalid !== 1'b0 || o_aready !== 1'b0) begin
         failures++; $display("FAIL midreset_in_reset rvalid=%b aready=%b expected 0,0", o_rvalid, o_aready);
      end
      reset = 1'b0;
      i_rready = 1'b0;
      @(posedge axi_clk); #1;
      checks++;
      if (o_aready !== 1'b1 || o_rvalid !== 1'b0) begin
         failures++; $display("FAIL midreset_release aready=%b rvalid=%b expected 1,0", o_aready, o_rvalid);
      end
      axi_read(32'h100, 8'h52, 8'd3, 2'd1, 1'b0, nb, lat, sb, rid, rresp);
      checks++;
      if (nb !== 4 || rbuf[0] !== DW'(1) || rbuf[1] !== DW'(2) || rbuf[2] !== DW'(3) || rbuf[3] !== DW'(4)) begin
         failures++; $display("FAIL midreset_retained got=%h,%h,%h,%h beats=%0d expected 1,2,3,4",
                              rbuf[0], rbuf[1], rbuf[2], rbuf[3], nb);
      end
      axi_read(32'h210, 8'h53, 8'd0, 2'd1, 1'b0, nb, lat, sb, rid, rresp);
      checks++;
      if (rbuf[0] !== DW'(32'h1001)) begin failures++; $display("FAIL midreset_word got=%h expected 1001", rbuf[0]); end
   endtask

   initial begin
      test_reset();
      test_incr_write_read();
      test_strobe();
      test_read_stall();
      test_addr_wrap();
      test_check();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
